// File: rtl/serialin_if.sv
// Pin-level bundle between the scanner and an external 74HC165-style chain.
interface serialin_if #(
  parameter int WIDTH = 8
);
  logic             sclk;
  logic             sload_n;
  logic             sdata;
  logic [WIDTH-1:0] data_out;
  logic             upd;

  modport master (output sclk, output sload_n, input sdata, output data_out, output upd);
  modport slave  (input sclk, input sload_n, output sdata, input data_out, input upd);
endinterface

// File: rtl/serialin.sv
// Free-running load/shift/debounce scanner for a parallel-in/serial-out switch chain.
// A frame is LOAD + GAP + WIDTH sclk periods + DONE; data_out moves after two equal frames.
module serialin #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic       clki,
  input  logic       rst,
  serialin_if.master bus
);
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bitn;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] shreg_shift;
  logic [WIDTH-1:0] data_q;
  logic             sclk_q;
  logic             sload_n_q;
  logic             upd_q;

  assign bus.sclk     = sclk_q;
  assign bus.sload_n  = sload_n_q;
  assign bus.data_out = data_q;
  assign bus.upd      = upd_q;

  generate
    if (WIDTH == 1) begin : g_w1
      assign shreg_shift = bus.sdata;
    end else begin : g_wn
      assign shreg_shift = {shreg[WIDTH-2:0], bus.sdata};
    end
  endgenerate

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      prev      <= '0;
      data_q    <= '0;
      sclk_q    <= 1'b0;
      sload_n_q <= 1'b1;
      upd_q     <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state)
        // IDLE spans one full cycle after release, so the load strobe starts on the 2nd edge
        S_IDLE: begin
          if (cnt == '0) begin
            cnt <= CW'(1);
          end else begin
            cnt       <= '0;
            state     <= S_LOAD;
            sload_n_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (cnt == FULL_LAST) begin
            cnt       <= '0;
            state     <= S_GAP;
            sload_n_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            bitn  <= '0;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt != HALF_LAST) begin
            cnt <= cnt + 1'b1;
          end else if (!sclk_q) begin
            // sample before our own rising sclk lets the chain advance
            cnt    <= '0;
            shreg  <= shreg_shift;
            sclk_q <= 1'b1;
          end else begin
            cnt    <= '0;
            sclk_q <= 1'b0;
            if (bitn == BIT_LAST) begin
              bitn  <= '0;
              state <= S_DONE;
            end else begin
              bitn <= bitn + 1'b1;
            end
          end
        end
        S_DONE: begin
          cnt       <= '0;
          state     <= S_LOAD;
          sload_n_q <= 1'b0;
          if (shreg != prev) begin
            prev <= shreg;
          end else if (shreg != data_q) begin
            data_q <= shreg;
            upd_q  <= 1'b1;
          end
        end
        default: begin
          cnt       <= '0;
          state     <= S_IDLE;
          sclk_q    <= 1'b0;
          sload_n_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serialin.sv
// Bench: two scanners (8-bit/div4 and 1-bit/div1) against 74HC165 chain models and a frame-level debounce model.
module tb_serialin;
  logic clki  = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clki = ~clki;

  serialin_if #(.WIDTH(8)) bus_a ();
  serialin_if #(.WIDTH(1)) bus_b ();

  serialin #(.WIDTH(8), .CLK_DIV(4)) dut_a (.clki(clki), .rst(rst_a), .bus(bus_a));
  serialin #(.WIDTH(1), .CLK_DIV(1)) dut_b (.clki(clki), .rst(rst_b), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Chain models: transparent while load is low, frozen on its rise, shift on sclk rise.
  logic [7:0] pin_a = 8'h00;
  logic [7:0] chain_a;
  logic [7:0] cap_a[$];
  always @(posedge bus_a.sload_n or posedge bus_a.sclk)
    if (bus_a.sclk) chain_a <= {chain_a[6:0], 1'b0};
    else begin
      chain_a <= pin_a;
      cap_a.push_back(pin_a);
    end
  assign bus_a.sdata = bus_a.sload_n ? chain_a[7] : pin_a[7];

  logic pin_b = 1'b0;
  logic chain_b;
  logic cap_b[$];
  always @(posedge bus_b.sload_n or posedge bus_b.sclk)
    if (bus_b.sclk) chain_b <= 1'b0;
    else begin
      chain_b <= pin_b;
      cap_b.push_back(pin_b);
    end
  assign bus_b.sdata = bus_b.sload_n ? chain_b : pin_b;

  // Frame-level reference: a frame is adopted when it equals the frame before it.
  logic [7:0] m_last_a, m_data_a, f_a;
  logic       sload_q_a, sclk_q_a, fall_a, exp_upd_a, first_a;
  int         cyc_a, rel_a, rises_a, run_a, frames_a = 0, upd_cnt_a = 0;
  always @(negedge clki) begin
    if (rst_a) begin
      cap_a.delete();
      m_last_a = '0; m_data_a = '0; first_a = 1'b1; sload_q_a = 1'b1; sclk_q_a = 1'b0;
      rel_a = 0; cyc_a = 0; rises_a = 0; run_a = 0;
      chk("a_rst_sclk", bus_a.sclk, 0);
      chk("a_rst_sload_n", bus_a.sload_n, 1);
      chk("a_rst_data", bus_a.data_out, 0);
      chk("a_rst_upd", bus_a.upd, 0);
    end else begin
      rel_a++; cyc_a++;
      fall_a    = sload_q_a && !bus_a.sload_n;
      exp_upd_a = 1'b0;
      if (fall_a) begin
        if (first_a) chk("a_first_load_edge", rel_a, 2);
        else begin
          chk("a_frame_len", cyc_a, 77);
          chk("a_sclk_rises", rises_a, 8);
          if (cap_a.size() > 0) begin
            f_a = cap_a.pop_front();
            if (f_a == m_last_a && f_a != m_data_a) begin
              m_data_a  = f_a;
              exp_upd_a = 1'b1;
            end
            m_last_a = f_a;
          end
        end
        first_a = 1'b0; cyc_a = 0; rises_a = 0; frames_a++;
      end
      if (bus_a.sclk !== sclk_q_a) begin
        if (sclk_q_a) chk("a_sclk_high_len", run_a, 4);
        else if (rises_a > 0) chk("a_sclk_low_len", run_a, 4);
        if (bus_a.sclk) rises_a++;
        run_a = 1;
      end else run_a++;
      chk("a_sclk_vs_load", bus_a.sclk & ~bus_a.sload_n, 0);
      chk("a_data_out", bus_a.data_out, m_data_a);
      chk("a_upd", bus_a.upd, exp_upd_a);
      if (bus_a.upd) upd_cnt_a++;
      sload_q_a = bus_a.sload_n;
      sclk_q_a  = bus_a.sclk;
    end
  end

  logic m_last_b, m_data_b, f_b, sload_q_b, fall_b, exp_upd_b, first_b;
  int   cyc_b, rel_b, rises_b, frames_b = 0, upd_cnt_b = 0;
  always @(negedge clki) begin
    if (rst_b) begin
      cap_b.delete();
      m_last_b = 1'b0; m_data_b = 1'b0; first_b = 1'b1; sload_q_b = 1'b1;
      rel_b = 0; cyc_b = 0; rises_b = 0;
      chk("b_rst_outputs", {bus_b.sclk, bus_b.sload_n, bus_b.data_out, bus_b.upd}, 4'b0100);
    end else begin
      rel_b++; cyc_b++;
      fall_b    = sload_q_b && !bus_b.sload_n;
      exp_upd_b = 1'b0;
      if (fall_b) begin
        if (first_b) chk("b_first_load_edge", rel_b, 2);
        else begin
          chk("b_frame_len", cyc_b, 6);
          chk("b_sclk_rises", rises_b, 1);
          if (cap_b.size() > 0) begin
            f_b = cap_b.pop_front();
            if (f_b == m_last_b && f_b != m_data_b) begin
              m_data_b  = f_b;
              exp_upd_b = 1'b1;
            end
            m_last_b = f_b;
          end
        end
        first_b = 1'b0; cyc_b = 0; rises_b = 0; frames_b++;
      end
      if (bus_b.sclk) rises_b++;
      chk("b_sclk_vs_load", bus_b.sclk & ~bus_b.sload_n, 0);
      chk("b_data_out", bus_b.data_out, m_data_b);
      chk("b_upd", bus_b.upd, exp_upd_b);
      if (bus_b.upd) upd_cnt_b++;
      sload_q_b = bus_b.sload_n;
    end
  end

  // Returns just after a negedge, with the monitors already updated for that cycle.
  task automatic wait_frames(input bit on_b, input int n);
    int target = (on_b ? frames_b : frames_a) + n;
    int t = 0;
    while ((on_b ? frames_b : frames_a) < target && t < n * 100) begin
      @(negedge clki); #1;
      t++;
    end
    if ((on_b ? frames_b : frames_a) < target) chk("frame_timeout", t, 0);
  endtask

  int u0, hold, t;
  initial begin
    // Reset with chain idle at 0x00: no updates over several frames.
    repeat (3) @(negedge clki);
    #1 rst_a = 1'b0;
    wait_frames(0, 5);
    chk("a_idle_upd_count", upd_cnt_a, 0);
    chk("a_idle_data", bus_a.data_out, 8'h00);

    // 0xA5: first DONE only primes, second DONE publishes with one strobe.
    pin_a = 8'hA5;
    u0 = upd_cnt_a;
    wait_frames(0, 1);
    chk("a5_after_one_frame", bus_a.data_out, 8'h00);
    wait_frames(0, 1);
    chk("a5_after_two_frames", bus_a.data_out, 8'hA5);
    wait_frames(0, 3);
    chk("a5_single_upd", upd_cnt_a - u0, 1);

    // Bit order: only the first shifted bit is set.
    pin_a = 8'h80;
    wait_frames(0, 2);
    chk("bit_order_80", bus_a.data_out, 8'h80);

    // Single-frame glitch rejected, two-frame value accepted.
    pin_a = 8'h00;
    wait_frames(0, 2);
    u0 = upd_cnt_a;
    pin_a = 8'h3C;
    wait_frames(0, 1);
    pin_a = 8'h00;
    wait_frames(0, 3);
    chk("glitch_data", bus_a.data_out, 8'h00);
    chk("glitch_no_upd", upd_cnt_a - u0, 0);
    pin_a = 8'h3C;
    wait_frames(0, 2);
    chk("held_3c_data", bus_a.data_out, 8'h3C);
    wait_frames(0, 2);
    chk("held_3c_one_upd", upd_cnt_a - u0, 1);

    // Asynchronous reset after bit 3 of a frame while 0xA5 is published.
    pin_a = 8'hA5;
    wait_frames(0, 3);
    chk("pre_reset_a5", bus_a.data_out, 8'hA5);
    t = 0;
    while (rises_a < 4 && t < 200) begin
      @(negedge clki); #1;
      t++;
    end
    chk("mid_shift_reached", rises_a, 4);
    @(negedge clki); #2;
    rst_a = 1'b1;
    #1;
    chk("async_data_out", bus_a.data_out, 8'h00);
    chk("async_sclk", bus_a.sclk, 0);
    chk("async_sload_n", bus_a.sload_n, 1);
    repeat (3) @(negedge clki);
    #1 rst_a = 1'b0;
    wait_frames(0, 2);
    chk("reacq_not_yet", bus_a.data_out, 8'h00);
    wait_frames(0, 1);
    chk("reacq_a5", bus_a.data_out, 8'hA5);

    // Random values, changed at random points in the frame, held 1..3 frames.
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 70)) @(negedge clki);
      #1 pin_a = 8'($urandom);
      hold = $urandom_range(1, 3);
      wait_frames(0, hold);
    end
    wait_frames(0, 3);
    chk("random_settled", bus_a.data_out, pin_a);

    // WIDTH=1, CLK_DIV=1: each toggle held two frames gives one strobe.
    #1 rst_b = 1'b0;
    wait_frames(1, 4);
    chk("b_idle_data", bus_b.data_out, 0);
    for (int i = 0; i < 6; i++) begin
      u0 = upd_cnt_b;
      pin_b = ~pin_b;
      wait_frames(1, 2);
      chk("b_toggle_data", bus_b.data_out, pin_b);
      wait_frames(1, 1);
      chk("b_toggle_one_upd", upd_cnt_b - u0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
